// File: rtl/max_scan.sv
// Burst maximum finder: scans 1..16 signed samples through an external comparator
// and reports the maximum, the index of its first occurrence, and its tie count.
module max_scan (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] len,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] cmp_a,
  output logic [7:0] cmp_b,
  input  logic       cmp_e,
  input  logic       cmp_k,
  input  logic       cmp_l,
  output logic       busy,
  output logic       done,
  output logic [7:0] max_out,
  output logic [3:0] max_idx,
  output logic [4:0] tie_cnt,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, FIRST, SCAN, DONE} state_t;

  state_t     state, state_next;
  logic [4:0] total;
  logic [4:0] count;
  logic [4:0] count_next;
  logic       flags_ok;

  assign cmp_a      = in_data;
  assign cmp_b      = max_out;
  assign count_next = count + 5'd1;
  assign flags_ok   = $onehot({cmp_e, cmp_k, cmp_l});

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = FIRST;
      end
      FIRST: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_next = (total == 5'd1) ? DONE : SCAN;
      end
      SCAN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && (count_next == total)) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result registers only move on accepted samples; an illegal flag set
  // still advances the sample count so the burst length is honoured.
  always_ff @(posedge clk) begin
    if (rst) begin
      total   <= 5'd0;
      count   <= 5'd0;
      max_out <= 8'h00;
      max_idx <= 4'd0;
      tie_cnt <= 5'd0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            total <= (len == 4'd0) ? 5'd16 : {1'b0, len};
            count <= 5'd0;
            err   <= 1'b0;
          end
        end
        FIRST: begin
          if (in_valid) begin
            max_out <= in_data;
            max_idx <= 4'd0;
            tie_cnt <= 5'd1;
            count   <= 5'd1;
          end
        end
        SCAN: begin
          if (in_valid) begin
            count <= count_next;
            if (!flags_ok) begin
              err <= 1'b1;
            end else if (cmp_k) begin
              max_out <= in_data;
              max_idx <= count[3:0];
              tie_cnt <= 5'd1;
            end else if (cmp_e) begin
              tie_cnt <= tie_cnt + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_max_scan.sv
// Self-checking bench for max_scan: models the external comparator and checks
// burst results against a behavioural maximum/first-index/tie-count model.
module tb_max_scan;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, in_ready;
  logic [3:0] len;
  logic [7:0] in_data, cmp_a, cmp_b, max_out;
  logic       cmp_e, cmp_k, cmp_l, busy, done, err;
  logic [3:0] max_idx;
  logic [4:0] tie_cnt;
  logic       force_bad;

  int n_tests = 0;
  int n_fail  = 0;

  max_scan dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_e(cmp_e), .cmp_k(cmp_k), .cmp_l(cmp_l),
    .busy(busy), .done(done), .max_out(max_out), .max_idx(max_idx),
    .tie_cnt(tie_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // External signed comparator, with an override that produces an illegal flag set.
  always_comb begin
    if (force_bad) begin
      cmp_e = 1'b1; cmp_k = 1'b1; cmp_l = 1'b0;
    end else begin
      cmp_e = (cmp_a == cmp_b);
      cmp_k = ($signed(cmp_a) > $signed(cmp_b));
      cmp_l = ($signed(cmp_a) < $signed(cmp_b));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Maximum over all samples except the one with bad flags, first index of it, number of equal samples.
  function automatic void ref_model(input logic [7:0] s[$], input int bad,
                                    output logic [7:0] m, output logic [3:0] idx,
                                    output logic [4:0] ties);
    int best;
    bit found;
    best = -129;
    for (int i = 0; i < s.size(); i++)
      if (i != bad && int'($signed(s[i])) > best) best = int'($signed(s[i]));
    m = best[7:0];
    idx = 4'd0; ties = 5'd0; found = 1'b0;
    for (int i = 0; i < s.size(); i++)
      if (i != bad && int'($signed(s[i])) == best) begin
        if (!found) idx = 4'(i);
        found = 1'b1;
        ties  = ties + 5'd1;
      end
  endfunction

  // Drives one burst from IDLE; returns what was observed around done and in_ready.
  task automatic drive_burst(input logic [3:0] l, input logic [7:0] s[$], input int bad,
                             input bit gaps, input bit junk,
                             output bit d_early, output bit d_ok, output bit d_after_ok,
                             output bit rdy_ok);
    start = 1'b1; len = l; in_valid = junk; in_data = 8'h7F;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    d_early = 1'b0; rdy_ok = 1'b1;
    for (int i = 0; i < s.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          in_valid = 1'b0; in_data = 8'($urandom);
          @(negedge clk);
          if (done) d_early = 1'b1;
        end
      end
      in_valid = 1'b1; in_data = s[i]; force_bad = (i == bad);
      start = junk && (i == 1);
      if (!in_ready || done) rdy_ok = 1'b0;
      @(negedge clk);
      if (done && i != s.size() - 1) d_early = 1'b1;
    end
    in_valid = 1'b0; force_bad = 1'b0; start = 1'b0;
    d_ok = done && busy && !in_ready;
    @(negedge clk);
    d_after_ok = !done && !busy && !in_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; len = 4'd0; in_valid = 1'b0; in_data = 8'h00; force_bad = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({max_out, max_idx, tie_cnt, err, done, busy, in_ready} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_state: got max=%h idx=%0d ties=%0d err=%b done=%b busy=%b rdy=%b, want all zero",
               max_out, max_idx, tie_cnt, err, done, busy, in_ready);
    end
  endtask

  task automatic test_directed();
    logic [7:0] s[$];
    logic [3:0] l, e_idx;
    logic [7:0] e_max;
    logic [4:0] e_ties;
    bit de, dok, dafter, rok;
    for (int t = 0; t < 3; t++) begin
      case (t)
        0: begin l = 4'd4; s = '{8'h03, 8'hFB, 8'h07, 8'h02}; end
        1: begin l = 4'd3; s = '{8'h80, 8'hFF, 8'hFF}; end
        default: begin l = 4'd1; s = '{8'h42}; end
      endcase
      ref_model(s, -1, e_max, e_idx, e_ties);
      drive_burst(l, s, -1, 1'b0, 1'b0, de, dok, dafter, rok);
      n_tests++;
      if (de || !dok || !dafter || !rok) begin
        n_fail++;
        $display("FAIL directed%0d_handshake: early=%b done_lat1=%b after=%b ready=%b, want 0 1 1 1",
                 t, de, dok, dafter, rok);
      end
      n_tests++;
      if ({max_out, max_idx, tie_cnt, err} !== {e_max, e_idx, e_ties, 1'b0}) begin
        n_fail++;
        $display("FAIL directed%0d_result: got max=%h idx=%0d ties=%0d err=%b, want max=%h idx=%0d ties=%0d err=0",
                 t, max_out, max_idx, tie_cnt, err, e_max, e_idx, e_ties);
      end
    end
    n_tests++;
    in_data = 8'h5A;
    #1;
    if (cmp_a !== 8'h5A || cmp_b !== 8'h42) begin
      n_fail++;
      $display("FAIL cmp_operands_idle: got a=%h b=%h, want a=5a b=42", cmp_a, cmp_b);
    end
  endtask

  task automatic test_len16_stalls();
    logic [7:0] s[$];
    bit de, dok, dafter, rok;
    s = {};
    for (int i = 0; i < 16; i++) s.push_back(8'h10);
    drive_burst(4'd0, s, -1, 1'b1, 1'b1, de, dok, dafter, rok);
    n_tests++;
    if (de || !dok || !dafter || !rok) begin
      n_fail++;
      $display("FAIL len16_handshake: early=%b done_lat1=%b after=%b ready=%b, want 0 1 1 1",
               de, dok, dafter, rok);
    end
    n_tests++;
    if ({max_out, max_idx, tie_cnt, err} !== {8'h10, 4'd0, 5'd16, 1'b0}) begin
      n_fail++;
      $display("FAIL len16_result: got max=%h idx=%0d ties=%0d err=%b, want max=10 idx=0 ties=16 err=0",
               max_out, max_idx, tie_cnt, err);
    end
  endtask

  task automatic test_reset_midscan();
    start = 1'b1; len = 4'd5;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 8'h11;
    @(negedge clk);
    in_data = 8'h22;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({max_out, max_idx, tie_cnt, err, done, busy, in_ready} !== 21'd0) begin
      n_fail++;
      $display("FAIL midscan_reset: got max=%h idx=%0d ties=%0d err=%b done=%b busy=%b rdy=%b, want all zero",
               max_out, max_idx, tie_cnt, err, done, busy, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'h55;
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || max_out !== 8'h00) begin
        n_fail++;
        $display("FAIL post_reset_ignore%0d: got rdy=%b busy=%b max=%h, want 0 0 00",
                 i, in_ready, busy, max_out);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_error();
    logic [7:0] s[$];
    bit de, dok, dafter, rok;
    s = '{8'h05, 8'h20, 8'h01};
    drive_burst(4'd3, s, 1, 1'b0, 1'b0, de, dok, dafter, rok);
    n_tests++;
    if (!dok || !dafter) begin
      n_fail++;
      $display("FAIL err_burst_done: done_lat1=%b after=%b, want 1 1", dok, dafter);
    end
    n_tests++;
    if ({max_out, max_idx, tie_cnt, err} !== {8'h05, 4'd0, 5'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL err_result: got max=%h idx=%0d ties=%0d err=%b, want max=05 idx=0 ties=1 err=1",
               max_out, max_idx, tie_cnt, err);
    end
    s = '{8'h01, 8'h02};
    drive_burst(4'd2, s, -1, 1'b0, 1'b0, de, dok, dafter, rok);
    n_tests++;
    if ({max_out, max_idx, tie_cnt, err} !== {8'h02, 4'd1, 5'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL err_cleared: got max=%h idx=%0d ties=%0d err=%b, want max=02 idx=1 ties=1 err=0",
               max_out, max_idx, tie_cnt, err);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s[$];
    bit de, dok, dafter, rok;
    s = '{8'hF0, 8'hF1};
    start = 1'b1; len = 4'd2; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = s[0];
    @(negedge clk);
    in_data = s[1];
    @(negedge clk);
    in_valid = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || max_out !== 8'hF1) begin
      n_fail++;
      $display("FAIL start_in_done_ignored: got busy=%b max=%h, want 0 f1", busy, max_out);
    end
    drive_burst(4'd2, s, -1, 1'b0, 1'b0, de, dok, dafter, rok);
    n_tests++;
    if (!dok || {max_out, max_idx, tie_cnt} !== {8'hF1, 4'd1, 5'd1}) begin
      n_fail++;
      $display("FAIL back_to_back: got done_lat1=%b max=%h idx=%0d ties=%0d, want 1 f1 1 1",
               dok, max_out, max_idx, tie_cnt);
    end
  endtask

  task automatic test_random();
    logic [7:0] s[$];
    logic [7:0] e_max;
    logic [3:0] e_idx;
    logic [4:0] e_ties;
    int total;
    bit de, dok, dafter, rok;
    for (int t = 0; t < 25; t++) begin
      total = $urandom_range(1, 16);
      s = {};
      for (int i = 0; i < total; i++)
        s.push_back(($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 6) - 3) : 8'($urandom));
      ref_model(s, -1, e_max, e_idx, e_ties);
      drive_burst(4'(total), s, -1, 1'b1, 1'($urandom_range(0, 1)), de, dok, dafter, rok);
      n_tests++;
      if (de || !dok || !dafter || !rok ||
          {max_out, max_idx, tie_cnt, err} !== {e_max, e_idx, e_ties, 1'b0}) begin
        n_fail++;
        $display("FAIL random%0d: len=%0d hs=%b%b%b%b got max=%h idx=%0d ties=%0d err=%b, want hs=0111 max=%h idx=%0d ties=%0d err=0",
                 t, total, de, dok, dafter, rok, max_out, max_idx, tie_cnt, err, e_max, e_idx, e_ties);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_len16_stalls();
    test_reset_midscan();
    test_error();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
